// File: rtl/pmi_fifo_sc_fwft_pkg.sv
// Shared constants for the single-clock FWFT FIFO: address-width helper,
// implementation selector strings and RAM style tags.
package pmi_fifo_sc_fwft_pkg;

    localparam int    DEF_DEPTH = 1024;

    localparam string IMPL_EBR  = "EBR";
    localparam string IMPL_LUT  = "LUT";

    localparam string STYLE_EBR = "block_ram";
    localparam string STYLE_LUT = "distributed";
    localparam string STYLE_BEH = "none";

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pmi_fifo_sc_fwft_ram.sv
// Simple dual-port RAM: synchronous write port, registered read port whose
// output register only loads on a read enable and otherwise holds.
module pmi_fifo_sc_fwft_ram
    import pmi_fifo_sc_fwft_pkg::*;
#(
    parameter int    WIDTH          = 8,
    parameter int    DEPTH          = DEF_DEPTH,
    parameter string IMPLEMENTATION = IMPL_EBR,
    parameter int    SIM_MODE       = 0
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [addr_w(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [addr_w(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    localparam string RAM_STYLE = (SIM_MODE != 0)               ? STYLE_BEH :
                                  (IMPLEMENTATION == IMPL_LUT)  ? STYLE_LUT : STYLE_EBR;

    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Only the attribute differs between branches; the cycle behaviour is identical.
    if (RAM_STYLE == STYLE_LUT) begin : g_lut
        (* syn_ramstyle = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= wdata;
        end

        always_comb rd_data_d = re ? mem[raddr] : rd_data_q;
    end else if (RAM_STYLE == STYLE_EBR) begin : g_ebr
        (* syn_ramstyle = "block_ram" *) logic [WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= wdata;
        end

        always_comb rd_data_d = re ? mem[raddr] : rd_data_q;
    end else begin : g_beh
        logic [WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= wdata;
        end

        always_comb rd_data_d = re ? mem[raddr] : rd_data_q;
    end

    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rdata = rd_data_q;

endmodule

// File: rtl/pmi_fifo_sc_fwft.sv
// Single-clock first-word-fall-through FIFO: RAM plus a read-valid stage and
// an output register that prefetch the head word without a read request.
module pmi_fifo_sc_fwft
    import pmi_fifo_sc_fwft_pkg::*;
#(
    parameter int    DEPTH          = DEF_DEPTH,
    parameter int    DEPTH_AFULL    = DEF_DEPTH - 1,
    parameter int    WIDTH          = 8,
    parameter string FAMILY         = "ecp5u",
    parameter string IMPLEMENTATION = IMPL_EBR,
    parameter int    SIM_MODE       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wren,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             afull,
    input  logic             rden,
    output logic [WIDTH-1:0] rdata,
    output logic             rdata_vld
);

    localparam int AW = addr_w(DEPTH);
    localparam int CW = AW + 1;

    // Vendor RAM attributes are only meaningful for ECP5 parts.
    localparam bit VENDOR_FAMILY = (FAMILY == "ecp5u") || (FAMILY == "ecp5um") ||
                                   (FAMILY == "ecp5um5g");
    localparam int RAM_SIM_MODE  = ((SIM_MODE != 0) || !VENDOR_FAMILY) ? 1 : 0;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ram_vld_q, ram_vld_d;
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             full_q, full_d;
    logic             afull_q, afull_d;

    logic             wr_acc;
    logic             pop;
    logic             out_take;
    logic             rd_issue;
    logic [CW-1:0]    mem_words;
    logic [WIDTH-1:0] ram_rdata;

    always_comb begin
        wr_acc    = wren & ~full_q;
        pop       = rden & out_vld_q;
        // Words still sitting in RAM exclude those already in the two pipeline stages.
        mem_words = count_q - CW'(ram_vld_q) - CW'(out_vld_q);
        out_take  = ram_vld_q & (~out_vld_q | pop);
        rd_issue  = (mem_words != '0) & (~ram_vld_q | out_take);

        wr_ptr_d  = wr_ptr_q + AW'(wr_acc);
        rd_ptr_d  = rd_ptr_q + AW'(rd_issue);
        count_d   = count_q + CW'(wr_acc) - CW'(pop);

        ram_vld_d = ram_vld_q;
        if (rd_issue) begin
            ram_vld_d = 1'b1;
        end else if (out_take) begin
            ram_vld_d = 1'b0;
        end

        out_vld_d = out_vld_q;
        rdata_d   = rdata_q;
        if (out_take) begin
            out_vld_d = 1'b1;
            rdata_d   = ram_rdata;
        end else if (pop) begin
            out_vld_d = 1'b0;
        end

        full_d  = (count_d == CW'(DEPTH));
        afull_d = (count_d >= CW'(DEPTH_AFULL));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ram_vld_q <= 1'b0;
            out_vld_q <= 1'b0;
            rdata_q   <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ram_vld_q <= ram_vld_d;
            out_vld_q <= out_vld_d;
            rdata_q   <= rdata_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
        end
    end

    pmi_fifo_sc_fwft_ram #(
        .WIDTH          (WIDTH),
        .DEPTH          (DEPTH),
        .IMPLEMENTATION (IMPLEMENTATION),
        .SIM_MODE       (RAM_SIM_MODE)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .re    (rd_issue),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign full      = full_q;
    assign afull     = afull_q;
    assign rdata     = rdata_q;
    assign rdata_vld = out_vld_q;

endmodule

// File: tb/tb_pmi_fifo_sc_fwft.sv
// Bench for pmi_fifo_sc_fwft: fixed vectors, directed corner sequences and
// random traffic checked against a queue model of the FIFO.
module tb_pmi_fifo_sc_fwft;

    localparam int DEPTH       = 1024;
    localparam int DEPTH_AFULL = 1023;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wren = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rden = 1'b0;
    logic       full, afull, rdata_vld;
    logic [7:0] rdata;

    always #5 clk = ~clk;

    pmi_fifo_sc_fwft dut (
        .clk       (clk),
        .rst       (rst),
        .wren      (wren),
        .wdata     (wdata),
        .full      (full),
        .afull     (afull),
        .rden      (rden),
        .rdata     (rdata),
        .rdata_vld (rdata_vld)
    );

    // Reference model: a word is visible two edges after its accepting edge
    // and stays at the head until popped.
    typedef struct {
        logic [7:0] data;
        int         t;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] got[$];
    int         edge_n = 0;
    int         n_chk  = 0;
    int         n_err  = 0;
    bit         saw_full;

    typedef struct {
        logic       wren;
        logic [7:0] wdata;
        logic       rden;
        logic       exp_vld;
        logic [7:0] exp_rdata;
        logic       exp_full;
        logic       exp_afull;
    } vec_t;

    vec_t vec[14];

    function automatic bit m_vld();
        return (mq.size() > 0) && (mq[0].t + 2 <= edge_n);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("full", full, mq.size() == DEPTH);
        chk("afull", afull, mq.size() >= DEPTH_AFULL);
        chk("rdata_vld", rdata_vld, m_vld());
        if (m_vld()) chk("rdata", rdata, mq[0].data);
        if (full) saw_full = 1'b1;
    endtask

    task automatic tick(input logic w, input logic [7:0] d, input logic r);
        bit         m_pop, m_acc, dut_pop;
        logic [7:0] dut_head;
        wren     = w;
        wdata    = d;
        rden     = r;
        m_pop    = r && m_vld();
        m_acc    = w && (mq.size() < DEPTH);
        dut_pop  = r && rdata_vld;
        dut_head = rdata;
        @(posedge clk);
        #1;
        edge_n++;
        if (m_pop) void'(mq.pop_front());
        if (m_acc) mq.push_back('{data: d, t: edge_n});
        if (dut_pop) got.push_back(dut_head);
        check_outputs();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        wren = 1'b0;
        rden = 1'b0;
        @(posedge clk);
        #1;
        edge_n++;
        mq.delete();
        got.delete();
        chk("rst_full", full, 0);
        chk("rst_afull", afull, 0);
        chk("rst_vld", rdata_vld, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;
    endtask

    task automatic drain_consumer(input int max_cycles);
        for (int c = 0; c < max_cycles; c++) begin
            if (mq.size() == 0 && !rdata_vld) break;
            tick(1'b0, 8'h00, rdata_vld);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{1'b1, 8'h5C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vec[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vec[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5C, 1'b0, 1'b0};
        vec[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vec[4]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vec[5]  = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vec[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
        vec[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
        vec[8]  = '{1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vec[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vec[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0};
        vec[11] = '{1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vec[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vec[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0};

        // Latency / pop timing vectors
        do_reset();
        for (int i = 0; i < 14; i++) begin
            tick(vec[i].wren, vec[i].wdata, vec[i].rden);
            chk($sformatf("vec%0d_vld", i), rdata_vld, vec[i].exp_vld);
            if (vec[i].exp_vld) chk($sformatf("vec%0d_rdata", i), rdata, vec[i].exp_rdata);
            chk($sformatf("vec%0d_full", i), full, vec[i].exp_full);
            chk($sformatf("vec%0d_afull", i), afull, vec[i].exp_afull);
        end

        // Empty pop, then a single word
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b0, 8'h00, 1'b1);
        chk("empty_pop_vld", rdata_vld, 0);
        tick(1'b1, 8'h77, 1'b0);
        drain_consumer(10);
        chk("empty_pop_cnt", got.size(), 1);
        if (got.size() == 1) chk("empty_pop_data", got[0], 8'h77);

        // Streaming with rden following rdata_vld
        do_reset();
        saw_full = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] iv;
            iv = i;
            tick(1'b1, iv[7:0], rdata_vld);
        end
        drain_consumer(20);
        chk("stream_cnt", got.size(), 1024);
        for (int k = 0; k < got.size() && k < 1024; k++) begin
            logic [31:0] kv;
            kv = k;
            if (got[k] !== kv[7:0]) chk($sformatf("stream_data%0d", k), got[k], kv[7:0]);
        end
        chk("stream_never_full", saw_full, 0);

        // Fill to full, dropped write, drain
        do_reset();
        for (int i = 1; i <= 1024; i++) begin
            logic [31:0] iv;
            iv = i;
            tick(1'b1, {1'b0, iv[6:0]}, 1'b0);
            if (i == 1022) chk("fill_afull_1022", afull, 0);
            if (i == 1023) begin
                chk("fill_afull_1023", afull, 1);
                chk("fill_full_1023", full, 0);
            end
            if (i == 1024) chk("fill_full_1024", full, 1);
        end
        tick(1'b1, 8'hAA, 1'b0);
        chk("drop_full", full, 1);
        got.delete();
        for (int c = 0; c < 1100; c++) begin
            if (got.size() == 1024 && !rdata_vld) break;
            tick(1'b0, 8'h00, 1'b1);
        end
        chk("fill_drain_cnt", got.size(), 1024);
        begin
            int n_aa = 0;
            foreach (got[k]) if (got[k] == 8'hAA) n_aa++;
            chk("fill_no_aa", n_aa, 0);
        end
        chk("fill_vld_after_drain", rdata_vld, 0);

        // Full with simultaneous write+pop: write dropped, full clears
        do_reset();
        for (int i = 0; i < 1024; i++) tick(1'b1, 8'h3C, 1'b0);
        chk("sim_full_pre", full, 1);
        tick(1'b1, 8'hAA, 1'b1);
        chk("sim_full_post_full", full, 0);
        chk("sim_full_post_afull", afull, 1);
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1);

        // Occupancy 512 with 100 cycles of simultaneous write+pop
        do_reset();
        for (int i = 0; i < 512; i++) tick(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 100; i++) tick(1'b1, 8'($urandom), 1'b1);
        chk("sim512_afull", afull, 0);
        chk("sim512_full", full, 0);

        // Reset mid-stream at occupancy 300
        do_reset();
        for (int i = 0; i < 300; i++) tick(1'b1, 8'($urandom), 1'b0);
        do_reset();
        tick(1'b1, 8'h01, 1'b0);
        tick(1'b1, 8'h02, 1'b0);
        drain_consumer(10);
        chk("rst_mid_cnt", got.size(), 2);
        if (got.size() == 2) begin
            chk("rst_mid_d0", got[0], 8'h01);
            chk("rst_mid_d1", got[1], 8'h02);
        end

        // Random traffic with varying write/read pressure
        do_reset();
        for (int ph = 0; ph < 8; ph++) begin
            int wp, rp;
            wp = (ph % 2 == 0) ? int'($urandom_range(60, 98)) : int'($urandom_range(5, 60));
            rp = (ph % 2 == 0) ? int'($urandom_range(5, 50))  : int'($urandom_range(40, 98));
            for (int c = 0; c < 600; c++)
                tick($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pmi_fifo_sc_fwft.md
# pmi_fifo_sc_fwft

Single-clock, first-word-fall-through (FWFT) FIFO for Lattice ECP5-class designs. It buffers a WIDTH-bit stream between a producer and a consumer in the same clock domain. The head word is presented on `rdata` with `rdata_vld` high without a prior read request. `rden` acts as a pop/acknowledge. It serves as the general-purpose FIFO primitive wrapped around an EBR/LUT memory.

## Interface
- `DEPTH`, 1024: number of storage words; power of two, ≥4.
- `DEPTH_AFULL`, 1023: occupancy at or above which `afull` asserts; 1 ≤ DEPTH_AFULL ≤ DEPTH.
- `WIDTH`, 8: data width in bits.
- `FAMILY`, "ecp5u": target family string; used only for the RAM style attribute.
- `IMPLEMENTATION`, "EBR": "EBR" selects block RAM, "LUT" selects distributed RAM; synthesis attribute only.
- `SIM_MODE`, 0: 1 selects the purely behavioural memory model (no vendor attributes). Cycle behaviour is identical for 0 and 1.

- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wren`  in  1  write request; accepted when `full`=0.
- `wdata`  in  WIDTH  write data, sampled with `wren`.
- `full`  out  1  occupancy == DEPTH.
- `afull`  out  1  occupancy ≥ DEPTH_AFULL.
- `rden`  in  1  pop head word; effective only when `rdata_vld`=1.
- `rdata`  out  WIDTH  head-of-FIFO word; valid while `rdata_vld`=1.
- `rdata_vld`  out  1  `rdata` holds a valid word.

## Operation
- Occupancy counts every accepted word not yet popped, including words in the read pipeline and the output register. The counter is log2(DEPTH)+1 bits.
- Write accept = `wren` & !`full`. A write while full is silently dropped: no pointer or count change, and no error flag.
- Pop = `rden` & `rdata_vld`. `rden` while `rdata_vld`=0 is ignored, so consumers may deassert `rden` late.
- Same-cycle accept and pop leaves occupancy unchanged. At full, the write is still dropped even if a pop occurs that cycle, because `full` is evaluated pre-edge.
- The output register refills from memory automatically whenever it is empty or being popped and memory holds unread data.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- `rdata` holds its last value while `rdata_vld`=0. Its contents are don't-care.
- Reset: pointers, count and pipeline valids are cleared. Outputs reset to `full`=0, `afull`=0, `rdata_vld`=0, `rdata`=0. Reset mid-operation discards all contents.

## Timing
- All outputs are registered.
- First-word latency: a word accepted at edge T into an empty FIFO drives `rdata_vld`=1 after edge T+2.
- Throughput: with `rden` held high and data available, one word is popped per cycle with no bubbles.
- Pop at edge T: the next word, if already in memory, is on `rdata` after edge T, so `rdata_vld` stays high.
- `full` and `afull` update on the same edge as the count change.
- Example: the 1024th accepted write asserts `full` after that edge, and the 1023rd asserts `afull` (DEPTH_AFULL=1023).
- The first pop after full deasserts `full` after that edge.

## Structure
- A shared package holds a `clog2`-derived address width constant and the RAM-style attribute strings.
- One sub-module, `pmi_fifo_sc_fwft_ram`: simple dual-port RAM with a synchronous write port and a registered read port. It takes the WIDTH, DEPTH, IMPLEMENTATION and SIM_MODE parameters.
- The top level holds the pointers, occupancy counter, flag logic and the FWFT prefetch/output-register control (one RAM-read-valid stage plus one output stage).

## Test plan
- Streaming: after reset, write 1024 consecutive words 0x00..0xFF repeating, one per cycle. The consumer drives `rden` <= `rdata_vld` each cycle. The read-out sequence must be identical and in order (0x00..0xFF ×4), with no loss or duplication. `full` is never asserted.
- Fill: write 1024 words with `rden`=0. `afull` rises after write 1023, and `full` after write 1024. A 1025th write with value 0xAA is dropped. Draining returns exactly 1024 words, never 0xAA. `rdata_vld` falls after the last pop.
- Latency: single write of 0x5C at edge T into an empty FIFO gives `rdata_vld`=1 and `rdata`=0x5C after edge T+2. A pop then gives `rdata_vld`=0 on the next edge.
- Empty pop: `rden`=1 for 10 cycles while empty leaves count 0, `rdata_vld`=0, and no pointer movement. A subsequent write reads back correctly.
- Simultaneous: at occupancy 512, run `wren`=`rden`=1 for 100 cycles. Occupancy stays 512 and the flags stay constant. At full, simultaneous write+pop drops the write and leaves occupancy at 1023.
- Reset mid-stream: assert `rst` at occupancy 300. The next cycle shows `full`=`afull`=`rdata_vld`=0 and `rdata`=0. After deasserting, new writes 0x01, 0x02 read back as 0x01, 0x02.
